// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared predecode constants for the fetch queue unit
package fetch_queue_unit_pkg;

    // 32-bit major opcodes
    localparam logic [6:0] ob    = 7'b1100011;
    localparam logic [6:0] ojal  = 7'b1101111;
    localparam logic [6:0] ojalr = 7'b1100111;

    // RVC quadrants and funct3 codes
    localparam logic [1:0] RVC_Q1      = 2'b01;
    localparam logic [1:0] RVC_Q2      = 2'b10;
    localparam logic [2:0] RVC_F3_JAL  = 3'b001;
    localparam logic [2:0] RVC_F3_J    = 3'b101;
    localparam logic [2:0] RVC_F3_BEQZ = 3'b110;
    localparam logic [2:0] RVC_F3_BNEZ = 3'b111;
    localparam logic [2:0] RVC_F3_JR   = 3'b100;  // funct4 100x in quadrant 10

    localparam logic [31:0] HALT_INS = 32'h0ff00513;
    localparam logic [1:0]  BHT_INIT = 2'b01;

endpackage

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// rtl/fetch_queue_unit_fetch_fifo.sv - synchronous fifo with flush buffering fetched instructions
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   FULL_CNT = {1'b1, {PTR_W{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with fetch queue and 2-bit branch history table
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int BHT_IDX_W = 8,
    parameter int FQ_DEPTH  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic [31:0]          out_PC,
    output logic                 ask_for,
    input  logic                 give_you,
    input  logic [31:0]          g_ins,
    output logic                 is_ins,
    output logic [31:0]          ins_addr,
    output logic [31:0]          ins,
    output logic                 pred_jmp,
    input  logic                 rob_rs_slb_full,
    input  logic                 rob_clear,
    input  logic [31:0]          rob_new_pc,
    input  logic                 cancel_stuck,
    input  logic                 is_res,
    input  logic [BHT_IDX_W-1:0] res_pc_part,
    input  logic                 res_jmp
);

    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    logic [31:0] pc;
    logic        stuck;
    logic [1:0]  bht [BHT_SIZE];

    logic        fq_full;
    logic        fq_empty;
    logic        fq_push;
    logic        fq_pop;
    logic        fq_flush;
    logic [64:0] fq_head;

    logic        accept;
    logic        is_rvc;
    logic [31:0] ins_len;
    logic        is_jal;
    logic        is_cj;
    logic        is_br;
    logic        is_cb;
    logic        is_stall;
    logic        bht_pred;
    logic        pred;
    logic [31:0] next_pc;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] cj_imm;
    logic [31:0] cb_imm;

    assign out_PC  = pc;
    // Registered occupancy only, so a full queue never sees push and pop together.
    assign ask_for = !stuck && !fq_full;
    assign accept  = give_you && ask_for;

    assign is_rvc  = (g_ins[1:0] != 2'b11);
    assign ins_len = is_rvc ? 32'd2 : 32'd4;

    assign is_jal = !is_rvc && (g_ins[6:0] == ojal);
    assign is_br  = !is_rvc && (g_ins[6:0] == ob);
    assign is_cj  = (g_ins[1:0] == RVC_Q1) &&
                    (g_ins[15:13] == RVC_F3_J || g_ins[15:13] == RVC_F3_JAL);
    assign is_cb  = (g_ins[1:0] == RVC_Q1) &&
                    (g_ins[15:13] == RVC_F3_BEQZ || g_ins[15:13] == RVC_F3_BNEZ);
    // jalr / c.jr / c.jalr / HALT: target unknown here, wait for the ROB
    assign is_stall = (!is_rvc && (g_ins[6:0] == ojalr)) ||
                      ((g_ins[1:0] == RVC_Q2) && (g_ins[15:13] == RVC_F3_JR) &&
                       (g_ins[11:7] != 5'd0) && (g_ins[6:2] == 5'd0)) ||
                      (g_ins == HALT_INS);

    assign j_imm  = {{12{g_ins[31]}}, g_ins[19:12], g_ins[20], g_ins[30:21], 1'b0};
    assign b_imm  = {{20{g_ins[31]}}, g_ins[7], g_ins[30:25], g_ins[11:8], 1'b0};
    assign cj_imm = {{20{g_ins[12]}}, g_ins[12], g_ins[8], g_ins[10:9], g_ins[6],
                     g_ins[7], g_ins[2], g_ins[11], g_ins[5:3], 1'b0};
    assign cb_imm = {{23{g_ins[12]}}, g_ins[12], g_ins[6:5], g_ins[2],
                     g_ins[11:10], g_ins[4:3], 1'b0};

    // Read of the current array contents gives the pre-write value on a same-index update.
    assign bht_pred = bht[pc[BHT_IDX_W:1]][1];
    assign pred     = (is_br || is_cb) && bht_pred;

    always_comb begin
        next_pc = pc + ins_len;
        if (is_stall) begin
            next_pc = pc;
        end else if (is_jal) begin
            next_pc = pc + j_imm;
        end else if (is_cj) begin
            next_pc = pc + cj_imm;
        end else if (is_br && bht_pred) begin
            next_pc = pc + b_imm;
        end else if (is_cb && bht_pred) begin
            next_pc = pc + cb_imm;
        end
    end

    assign fq_push  = rdy_in && !rob_clear && accept;
    assign fq_pop   = rdy_in && !rob_clear && !fq_empty && !rob_rs_slb_full;
    assign fq_flush = rdy_in && rob_clear;

    fetch_fifo #(
        .WIDTH (65),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fq_push),
        .push_data ({pc, g_ins, pred}),
        .pop       (fq_pop),
        .flush     (fq_flush),
        .full      (fq_full),
        .empty     (fq_empty),
        .head      (fq_head)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (rdy_in && is_res) begin
            if (res_jmp && bht[res_pc_part] != 2'b11) begin
                bht[res_pc_part] <= bht[res_pc_part] + 2'b01;
            end else if (!res_jmp && bht[res_pc_part] != 2'b00) begin
                bht[res_pc_part] <= bht[res_pc_part] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc       <= '0;
            stuck    <= 1'b0;
            is_ins   <= 1'b0;
            ins_addr <= '0;
            ins      <= '0;
            pred_jmp <= 1'b0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                pc     <= rob_new_pc;
                stuck  <= 1'b0;
                is_ins <= 1'b0;
            end else begin
                is_ins <= fq_pop;
                if (fq_pop) begin
                    {ins_addr, ins, pred_jmp} <= fq_head;
                end
                if (accept) begin
                    pc    <= next_pc;
                    stuck <= is_stall;
                end else if (stuck && cancel_stuck) begin
                    pc    <= rob_new_pc;
                    stuck <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;

    localparam int FQ_DEPTH  = 4;
    localparam int BHT_IDX_W = 8;

    localparam logic [31:0] ADDI   = 32'h00108093;
    localparam logic [31:0] BEQ16  = 32'h00000863;
    localparam logic [31:0] CADDI  = 32'h00000505;
    localparam logic [31:0] JAL100 = 32'h1000006f;
    localparam logic [31:0] CJ8    = 32'h0000a021;
    localparam logic [31:0] CBEQZ4 = 32'h0000c011;
    localparam logic [31:0] JALR   = 32'h00008067;
    localparam logic [31:0] CJR    = 32'h00008082;
    localparam logic [31:0] HALT   = 32'h0ff00513;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic [31:0]          out_PC;
    logic                 ask_for;
    logic                 give_you;
    logic [31:0]          g_ins;
    logic                 is_ins;
    logic [31:0]          ins_addr;
    logic [31:0]          ins;
    logic                 pred_jmp;
    logic                 rob_rs_slb_full;
    logic                 rob_clear;
    logic [31:0]          rob_new_pc;
    logic                 cancel_stuck;
    logic                 is_res;
    logic [BHT_IDX_W-1:0] res_pc_part;
    logic                 res_jmp;

    int          vectors;
    int          miscompares;
    logic [31:0] m_pc;
    logic        m_stuck;
    logic        m_is_ins;
    logic [64:0] m_last;
    logic [64:0] sb [$];

    fetch_queue_unit #(
        .BHT_IDX_W (BHT_IDX_W),
        .FQ_DEPTH  (FQ_DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .out_PC          (out_PC),
        .ask_for         (ask_for),
        .give_you        (give_you),
        .g_ins           (g_ins),
        .is_ins          (is_ins),
        .ins_addr        (ins_addr),
        .ins             (ins),
        .pred_jmp        (pred_jmp),
        .rob_rs_slb_full (rob_rs_slb_full),
        .rob_clear       (rob_clear),
        .rob_new_pc      (rob_new_pc),
        .cancel_stuck    (cancel_stuck),
        .is_res          (is_res),
        .res_pc_part     (res_pc_part),
        .res_jmp         (res_jmp)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
    task automatic tick(input logic [31:0] delta, input logic epred, input logic estall);
        logic        ask;
        logic        acc;
        logic        pop;
        logic        stuck_b;
        logic [64:0] ent;
        ask = !m_stuck && (sb.size() < FQ_DEPTH);
        chk("ask_for", 65'(ask_for), 65'(ask));
        chk("out_PC", 65'(out_PC), 65'(m_pc));
        acc     = give_you && ask;
        pop     = (sb.size() != 0) && !rob_rs_slb_full;
        stuck_b = m_stuck;
        ent     = {m_pc, g_ins, epred};
        @(posedge clk_in);
        #1;
        if (rst_in) begin
            m_pc = '0; m_stuck = 1'b0; sb.delete(); m_is_ins = 1'b0; m_last = '0;
        end else if (!rdy_in) begin
            m_is_ins = m_is_ins;
        end else if (rob_clear) begin
            m_pc = rob_new_pc; m_stuck = 1'b0; sb.delete(); m_is_ins = 1'b0;
        end else begin
            m_is_ins = pop;
            if (pop) m_last = sb.pop_front();
            if (acc) begin
                sb.push_back(ent);
                m_pc    = m_pc + delta;
                m_stuck = estall;
            end else if (stuck_b && cancel_stuck) begin
                m_pc    = rob_new_pc;
                m_stuck = 1'b0;
            end
        end
        chk("is_ins", 65'(is_ins), 65'(m_is_ins));
        chk("ins_addr", 65'(ins_addr), 65'(m_last[64:33]));
        chk("ins", 65'(ins), 65'(m_last[32:1]));
        chk("pred_jmp", 65'(pred_jmp), 65'(m_last[0]));
    endtask

    task automatic feed(input logic [31:0] word, input logic [31:0] delta,
                        input logic epred, input logic estall);
        give_you = 1'b1;
        g_ins    = word;
        tick(delta, epred, estall);
        give_you = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(32'd0, 1'b0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] addr);
        rob_clear  = 1'b1;
        rob_new_pc = addr;
        tick(32'd0, 1'b0, 1'b0);
        rob_clear  = 1'b0;
    endtask

    task automatic cancel(input logic [31:0] addr);
        cancel_stuck = 1'b1;
        rob_new_pc   = addr;
        tick(32'd0, 1'b0, 1'b0);
        cancel_stuck = 1'b0;
    endtask

    task automatic train(input logic dir, input int n);
        is_res      = 1'b1;
        res_pc_part = 8'h10;
        res_jmp     = dir;
        for (int i = 0; i < n; i++) tick(32'd0, 1'b0, 1'b0);
        is_res      = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_in = 1'b1; rdy_in = 1'b1; give_you = 1'b0; g_ins = '0;
        rob_rs_slb_full = 1'b0; rob_clear = 1'b0; rob_new_pc = '0;
        cancel_stuck = 1'b0; is_res = 1'b0; res_pc_part = '0; res_jmp = 1'b0;
        m_pc = '0; m_stuck = 1'b0; m_is_ins = 1'b0; m_last = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("rst_is_ins", 65'(is_ins), 65'(0));
        chk("rst_ins_addr", 65'(ins_addr), 65'(0));
        chk("rst_ins", 65'(ins), 65'(0));
        chk("rst_pred_jmp", 65'(pred_jmp), 65'(0));
        chk("rst_out_PC", 65'(out_PC), 65'(0));
        chk("rst_ask_for", 65'(ask_for), 65'(1));

        // Sequential ADDIs at 0, 4, 8, 12
        for (int i = 0; i < 4; i++) feed(ADDI, 32'd4, 1'b0, 1'b0);
        idle(3);

        // Back-pressure fills the queue, then drains in order
        rob_rs_slb_full = 1'b1;
        for (int i = 0; i < 10; i++) feed(ADDI, 32'd4, 1'b0, 1'b0);
        rob_rs_slb_full = 1'b0;
        idle(6);

        // BHT: two increments -> taken
        train(1'b1, 2);
        feed(BEQ16, 32'd16, 1'b1, 1'b0);
        idle(3);
        // third increment in the same cycle as a flush saturates at 11
        is_res = 1'b1; res_pc_part = 8'h10; res_jmp = 1'b1;
        redirect(32'h20);
        is_res = 1'b0;
        feed(BEQ16, 32'd16, 1'b1, 1'b0);
        idle(2);
        train(1'b0, 3);
        redirect(32'h20);
        feed(BEQ16, 32'd4, 1'b0, 1'b0);
        idle(2);
        train(1'b0, 1);
        train(1'b1, 2);
        redirect(32'h20);
        // same-cycle decrement: lookup sees pre-write 10
        is_res = 1'b1; res_pc_part = 8'h10; res_jmp = 1'b0;
        feed(BEQ16, 32'd16, 1'b1, 1'b0);
        is_res = 1'b0;
        idle(2);
        redirect(32'h20);
        feed(BEQ16, 32'd4, 1'b0, 1'b0);
        idle(2);

        // RVC and jumps: 0x40 -> 0x42 -> 0x142 -> 0x14a -> 0x14c
        redirect(32'h40);
        feed(CADDI, 32'd2, 1'b0, 1'b0);
        feed(JAL100, 32'h100, 1'b0, 1'b0);
        feed(CJ8, 32'd8, 1'b0, 1'b0);
        feed(CBEQZ4, 32'd2, 1'b0, 1'b0);
        idle(3);

        // jalr stall and release
        redirect(32'h80);
        feed(JALR, 32'd0, 1'b0, 1'b1);
        give_you = 1'b1; g_ins = ADDI;
        for (int i = 0; i < 3; i++) tick(32'd4, 1'b0, 1'b0);
        give_you = 1'b0;
        cancel(32'h200);
        cancel(32'h300);
        feed(CJR, 32'd0, 1'b0, 1'b1);
        cancel(32'h210);
        feed(HALT, 32'd0, 1'b0, 1'b1);
        give_you = 1'b1; g_ins = ADDI;
        for (int i = 0; i < 3; i++) tick(32'd4, 1'b0, 1'b0);
        give_you = 1'b0;
        cancel(32'h300);
        idle(2);

        // Flush with three queued entries and a response in the same cycle
        rob_rs_slb_full = 1'b1;
        for (int i = 0; i < 3; i++) feed(ADDI, 32'd4, 1'b0, 1'b0);
        give_you = 1'b1; g_ins = ADDI;
        redirect(32'h500);
        give_you = 1'b0;
        rob_rs_slb_full = 1'b0;
        idle(3);

        // rdy_in low holds everything
        feed(ADDI, 32'd4, 1'b0, 1'b0);
        feed(ADDI, 32'd4, 1'b0, 1'b0);
        rdy_in = 1'b0; give_you = 1'b1; g_ins = ADDI; is_res = 1'b1;
        for (int i = 0; i < 2; i++) tick(32'd4, 1'b0, 1'b0);
        rdy_in = 1'b1; give_you = 1'b0; is_res = 1'b0;
        idle(3);

        // Reset mid-queue and mid-stall
        rob_rs_slb_full = 1'b1;
        feed(ADDI, 32'd4, 1'b0, 1'b0);
        feed(JALR, 32'd0, 1'b0, 1'b1);
        rst_in = 1'b1;
        tick(32'd0, 1'b0, 1'b0);
        rst_in = 1'b0;
        rob_rs_slb_full = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction fetch stage with a decoupling fetch queue and a configurable 2-bit branch history table (BHT). It drives the PC to the instruction cache and predicts conditional branches, RVC and 32-bit alike. It follows `jal`/`c.j`/`c.jal`, halts on `jalr`/`c.jr`/`c.jalr`/HALT until the ROB redirects, and buffers fetched instructions so decoder back-pressure does not stall the cache handshake. It sits between the instruction cache and the decoder and takes flush and predictor-training inputs from the ROB.

## Interface
- `BHT_IDX_W`, default 8: BHT has 2^BHT_IDX_W entries, indexed by `pc[BHT_IDX_W:1]`.
- `FQ_DEPTH`, default 4: fetch-queue entries; must be a power of two and at least 2.
- `clk_in` input, 1 bit: clock. One clock domain; reset is synchronous and active-high.
- `rst_in` input, 1 bit: synchronous, active-high reset.
- `rdy_in` input, 1 bit: global enable; when low, all state holds.
- `out_PC` output, 32 bits: fetch address to the icache.
- `ask_for` output, 1 bit: fetch request, equal to `!stuck && !fq_full`.
- `give_you` input, 1 bit: icache returns the instruction for `out_PC`.
- `g_ins` input, 32 bits: instruction word; RVC instructions occupy bits [15:0].
- `is_ins` output, 1 bit: one-cycle valid for the decoder outputs.
- `ins_addr` output, 32 bits: PC of the issued instruction.
- `ins` output, 32 bits: issued instruction.
- `pred_jmp` output, 1 bit: predicted-taken flag for the issued instruction.
- `rob_rs_slb_full` input, 1 bit: downstream full; blocks queue pop.
- `rob_clear` input, 1 bit: misprediction flush.
- `rob_new_pc` input, 32 bits: redirect target for both `rob_clear` and `cancel_stuck`.
- `cancel_stuck` input, 1 bit: release a jalr stall.
- `is_res` input, 1 bit: branch-resolution strobe.
- `res_pc_part` input, BHT_IDX_W bits: BHT index of the resolved branch.
- `res_jmp` input, 1 bit: resolved direction.

## Operation
- **Reset:** PC=0, stuck=0, queue empty, `is_ins`=0, `ins_addr`=0, `ins`=0, `pred_jmp`=0, all BHT counters=2'b01 (weakly not-taken).
- **Priority:** `rst_in`, then `!rdy_in` (full hold, including BHT writes), then `rob_clear`, then normal operation.
- **`rob_clear`:** PC←`rob_new_pc`, stuck←0, queue emptied, `is_ins`←0. The response arriving that cycle is discarded. BHT contents are kept, and any `is_res` update in the same cycle is still applied.
- **Accept:** occurs when `give_you && ask_for`. Length is 4 if `g_ins[1:0]==2'b11`, else 2. The pushed entry is {PC, g_ins, pred}. Next PC:
  - `jal` (opcode 1101111): PC+J-imm; `c.j`/`c.jal` (quadrant 01, funct3 101/001): PC+CJ-imm.
  - Conditional branch (opcode 1100011) or `c.beqz`/`c.bnez` (quadrant 01, funct3 110/111): pred=`bht[PC[BHT_IDX_W:1]][1]`. Next PC is PC+B-imm (or CB-imm) when pred=1, otherwise PC+length.
  - `jalr`, `c.jr`/`c.jalr` (quadrant 10, funct4 100x, rs1≠0, rs2=0), or HALT word `32'h0ff00513`: stuck←1, PC unchanged.
  - Everything else: PC+length, pred=0.
  - All immediate arithmetic is mod 2^32.
- **Stuck:** `ask_for`=0 and the queue keeps draining. On `cancel_stuck`: PC←`rob_new_pc`, stuck←0. `cancel_stuck` is ignored when not stuck.
- **Pop:** occurs when the queue is non-empty and `!rob_rs_slb_full`. On the next edge the head is registered to `ins`/`ins_addr`/`pred_jmp` with `is_ins`=1; otherwise `is_ins`=0 and the data outputs hold.
- **BHT training:** on `is_res`, a saturating increment if `res_jmp`, else a saturating decrement. Saturation is at 2'b11 and 2'b00.
- **Same-cycle read/write:** a lookup in the same cycle as a write to the same index uses the pre-write value.

## Timing
- Instruction accepted at edge t becomes queue head after t, pops at edge t+1, and `is_ins`=1 during cycle t+1→t+2. Minimum latency is 2 cycles.
- Pop and push in the same cycle on a full queue is not permitted: `ask_for` is computed from the registered occupancy. Push and pop in the same cycle on a non-full queue keeps occupancy.
- Pointer wrap-around is modulo FQ_DEPTH. Occupancy uses a log2(FQ_DEPTH)+1-bit counter.
- `out_PC` changes one cycle after accept, redirect, or cancel.
- `rst_in` mid-stall or mid-queue returns to the reset state on the next edge.

## Structure
- Shared package constants: opcodes (`ob`, `ojal`, `ojalr`), RVC quadrant/funct3 codes, `HALT_INS`, `BHT_INIT` = 2'b01.
- Sub-module `fetch_fifo`: a parametrised synchronous FIFO (width 65, depth FQ_DEPTH) with push, pop, flush, full, empty and head.
- The top level holds the PC/stuck state, predecode, immediate generation and the BHT array.

## Test plan
- Reset, then 4 sequential ADDI words at 0, 4, 8, 12 with `give_you` every cycle → `ins_addr` 0, 4, 8, 12, `is_ins` from cycle 2, `pred_jmp`=0.
- `rob_rs_slb_full`=1 for 10 cycles with FQ_DEPTH=4 → exactly 4 accepts, `ask_for`=0 after; on release, 4 pops in order, none lost.
- `beq` at 0x20 with imm +16, and `is_res`/`res_jmp`=1 at index 0x10 ×2 beforehand → `pred_jmp`=1, `out_PC`=0x30. A third training and a decrement ×3 saturate at 11 and then reach 00.
- `c.addi` (0x0505) at 0x40, then `jal` +0x100 at 0x42 → `out_PC` sequence 0x40, 0x42, 0x142.
- `jalr` at 0x80 → `ask_for`=0; `cancel_stuck`, `rob_new_pc`=0x200 → `out_PC`=0x200. HALT → stuck persists.
- Queue holding 3 entries, `rob_clear` with `rob_new_pc`=0x500 and `give_you` in the same cycle → queue empty, no `is_ins`, next `out_PC`=0x500.
